// File: rtl/pipe_stage_buf_pkg.sv
// rtl/pipe_stage_buf_pkg.sv - shared pipeline-register constants and state encoding
package pipe_stage_buf_pkg;

    localparam int PSB_STATE_W = 2;

    // Encoding doubles as the occupancy count driven on occ_o.
    typedef enum logic [PSB_STATE_W-1:0] {
        PSB_EMPTY = 2'd0,
        PSB_ONE   = 2'd1,
        PSB_FULL  = 2'd2
    } psb_state_e;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - WIDTH-bit storage slot with load-enable and synchronous clear
// Ports:
//   clk, rst  - clock (rising edge), asynchronous active-high reset
//   clr_i     - synchronous clear to CLEAR_VAL (wins over load_i)
//   load_i    - load d_i at the next edge
//   d_i       - data in
//   q_o       - registered data out
module pipe_slot #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] val_d;
    logic [WIDTH-1:0] val_q;

    always_comb begin
        val_d = val_q;
        if (clr_i) begin
            val_d = CLEAR_VAL;
        end else if (load_i) begin
            val_d = d_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= CLEAR_VAL;
        end else begin
            val_q <= val_d;
        end
    end

    assign q_o = val_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - inter-stage pipeline register with 2-entry skid storage and flush
// Ports:
//   clk, rst              - clock (rising edge), asynchronous active-high reset
//   flush_i               - synchronous kill of all held entries
//   up_valid_i/up_data_i  - upstream offer
//   up_ready_o            - accept this cycle (registered-state decode only)
//   dn_valid_o/dn_data_o  - downstream offer (main slot)
//   dn_ready_i            - downstream accepts this cycle
//   occ_o                 - entries held (0..2)
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    output logic             up_ready_o,
    output logic             dn_valid_o,
    output logic [WIDTH-1:0] dn_data_o,
    input  logic             dn_ready_i,
    output logic [1:0]       occ_o
);

    psb_state_e       state_d;
    psb_state_e       state_q;

    logic             main_load;
    logic             main_clr;
    logic [WIDTH-1:0] main_src;
    logic [WIDTH-1:0] main_val;
    logic             skid_load;
    logic             skid_clr;
    logic [WIDTH-1:0] skid_val;

    logic             up_fire;
    logic             dn_fire;

    // Ready comes from state only, so dn_ready_i never reaches up_ready_o.
    assign up_ready_o = (state_q != PSB_FULL);
    assign dn_valid_o = (state_q != PSB_EMPTY);
    assign dn_data_o  = main_val;
    assign occ_o      = state_q;

    assign up_fire = up_valid_i & up_ready_o;
    assign dn_fire = dn_valid_o & dn_ready_i;

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        main_src  = up_data_i;
        skid_load = 1'b0;
        skid_clr  = 1'b0;

        if (flush_i) begin
            // Any upstream offer this cycle is dropped; a dn_fire already happened.
            state_d  = PSB_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                PSB_ONE: begin
                    if (up_fire && dn_fire) begin
                        main_load = 1'b1;
                    end else if (up_fire) begin
                        skid_load = 1'b1;
                        state_d   = PSB_FULL;
                    end else if (dn_fire) begin
                        // Main keeps its stale value; dn_valid_o masks it.
                        state_d = PSB_EMPTY;
                    end
                end
                PSB_FULL: begin
                    if (dn_fire) begin
                        main_load = 1'b1;
                        main_src  = skid_val;
                        skid_clr  = 1'b1;
                        state_d   = PSB_ONE;
                    end
                end
                default: begin
                    // EMPTY, and the unused code 3 which behaves as EMPTY.
                    if (up_fire) begin
                        main_load = 1'b1;
                        state_d   = PSB_ONE;
                    end else begin
                        state_d = PSB_EMPTY;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PSB_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_slot #(
        .WIDTH     (WIDTH),
        .CLEAR_VAL (CLEAR_VAL)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (main_clr),
        .load_i (main_load),
        .d_i    (main_src),
        .q_o    (main_val)
    );

    pipe_slot #(
        .WIDTH     (WIDTH),
        .CLEAR_VAL (CLEAR_VAL)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (skid_clr),
        .load_i (skid_load),
        .d_i    (up_data_i),
        .q_o    (skid_val)
    );

endmodule
